// File: rtl/wb_decoder_pkg.sv
// Shared types and constants for the Wishbone address decoder.
// FSM state encoding, timeout counter width and default timeout.
package wb_decoder_pkg;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERR,
        DRAIN
    } state_t;

endpackage

// File: rtl/wb_timeout.sv
// Saturating no-ack cycle counter for the Wishbone decoder.
// expired is high once TIMEOUT-1 running cycles have been counted.
module wb_timeout
    import wb_decoder_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (run && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/wb_decoder.sv
// Wishbone 1-to-N address decoder with timeout and error drain.
// Optional fault address log: define WB_DECODER_FAULT_LOG_EN.
module wb_decoder
    import wb_decoder_pkg::*;
#(
    parameter int                NPORTS   = 16,
    parameter int                BASE     = 28,
    parameter logic [NPORTS-1:0] PORT_MAP = '1,
    parameter int                TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 m_cyc,
    input  logic                 m_stb,
    input  logic                 m_we,
    input  logic [31:0]          m_adr,
    input  logic [3:0]           m_sel,
    input  logic [31:0]          m_dat_i,
    output logic [31:0]          m_dat_o,
    output logic                 m_ack,
    output logic                 m_err,
    output logic [NPORTS-1:0]    p_cyc,
    output logic [NPORTS-1:0]    p_stb,
    output logic                 p_we,
    output logic [31:0]          p_adr,
    output logic [3:0]           p_sel,
    output logic [31:0]          p_dat_o,
    input  logic [NPORTS-1:0]    p_ack,
    input  logic [NPORTS*32-1:0] p_dat_i,
    output logic                 bus_error
`ifdef WB_DECODER_FAULT_LOG_EN
    ,
    output logic [31:0]          fault_adr,
    output logic                 fault_valid,
    input  logic                 fault_clr
`endif
);

    localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    state_t          state, state_n;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   sel;
    logic            req;
    logic            clr;
    logic            run;
    logic            expired;

    assign sel = m_adr[BASE +: SW];
    assign req = m_cyc && m_stb;

    assign p_we    = m_we;
    assign p_adr   = m_adr;
    assign p_sel   = m_sel;
    assign p_dat_o = m_dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req && PORT_MAP[sel]) begin
                sel_q <= sel;
            end
        end
    end

    wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (clr),
        .run     (run),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        p_cyc   = '0;
        p_stb   = '0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_dat_o = '0;
        clr     = 1'b0;
        run     = 1'b0;
        unique case (state)
            IDLE: begin
                clr = 1'b1;
                if (req) begin
                    state_n = PORT_MAP[sel] ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                p_cyc[sel_q] = m_cyc;
                p_stb[sel_q] = m_stb;
                m_ack        = p_ack[sel_q];
                m_dat_o      = p_dat_i[{sel_q, 5'd0} +: 32];
                if (!m_cyc) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                end else if (p_ack[sel_q]) begin
                    state_n = IDLE;
                end else if (expired) begin
                    state_n = ERR;
                end else begin
                    run = 1'b1;
                end
            end
            ERR: begin
                m_err   = 1'b1;
                state_n = DRAIN;
            end
            DRAIN: begin
                if (!m_cyc) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs are quiet for the whole reset cycle, not just after it.
        if (rst_i) begin
            p_cyc   = '0;
            p_stb   = '0;
            m_ack   = 1'b0;
            m_err   = 1'b0;
            m_dat_o = '0;
        end
    end

    assign bus_error = m_err;

`ifdef WB_DECODER_FAULT_LOG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_adr   <= '0;
            fault_valid <= 1'b0;
        end else if (m_err && (!fault_valid || fault_clr)) begin
            fault_adr   <= m_adr;
            fault_valid <= 1'b1;
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_decoder.sv
// Directed and randomized checks of wb_decoder against a
// transaction-level model of termination cycle and type.
module tb_wb_decoder;

    localparam int          NP  = 16;
    localparam int          T   = 8;
    localparam logic [15:0] MAP = 16'h00FF;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m_cyc, m_stb, m_we;
    logic [31:0]       m_adr;
    logic [3:0]        m_sel;
    logic [31:0]       m_dat_i;
    logic [31:0]       m_dat_o;
    logic              m_ack, m_err;
    logic [NP-1:0]     p_cyc, p_stb;
    logic              p_we;
    logic [31:0]       p_adr;
    logic [3:0]        p_sel;
    logic [31:0]       p_dat_o;
    logic [NP-1:0]     p_ack;
    logic [NP*32-1:0]  p_dat_i;
    logic              bus_error;
`ifdef WB_DECODER_FAULT_LOG_EN
    logic [31:0]       fault_adr;
    logic              fault_valid;
    logic              fault_clr;
    logic [31:0]       fa_m;
    logic              fv_m;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] pdat [NP];

    wb_decoder #(
        .NPORTS   (NP),
        .BASE     (28),
        .PORT_MAP (MAP),
        .TIMEOUT  (T)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_adr     (m_adr),
        .m_sel     (m_sel),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .p_cyc     (p_cyc),
        .p_stb     (p_stb),
        .p_we      (p_we),
        .p_adr     (p_adr),
        .p_sel     (p_sel),
        .p_dat_o   (p_dat_o),
        .p_ack     (p_ack),
        .p_dat_i   (p_dat_i),
`ifdef WB_DECODER_FAULT_LOG_EN
        .fault_adr   (fault_adr),
        .fault_valid (fault_valid),
        .fault_clr   (fault_clr),
`endif
        .bus_error (bus_error)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        chk({tag, ".p_stb"}, 32'(p_stb), 0);
        chk({tag, ".p_cyc"}, 32'(p_cyc), 0);
        chk({tag, ".m_ack"}, 32'(m_ack), 0);
        chk({tag, ".m_err"}, 32'(m_err), 0);
        chk({tag, ".bus_error"}, 32'(bus_error), 0);
        chk({tag, ".m_dat_o"}, m_dat_o, 0);
    endtask

    task automatic chk_fault(input string tag);
`ifdef WB_DECODER_FAULT_LOG_EN
        chk({tag, ".fault_valid"}, 32'(fault_valid), 32'(fv_m));
        chk({tag, ".fault_adr"}, fault_adr, fa_m);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    task automatic set_clr(input bit v);
`ifdef WB_DECODER_FAULT_LOG_EN
        fault_clr = v;
`else
        if (v) $display("fault log not built");
`endif
    endtask

    task automatic new_data();
        for (int i = 0; i < NP; i++) begin
            pdat[i] = $urandom;
            p_dat_i[i*32 +: 32] = pdat[i];
        end
    endtask

    // Model: decide termination kind and cycle from the rules, then
    // walk the transaction cycle by cycle. Cycle 0 is the strobe cycle.
    task automatic txn(input logic [31:0] adr, input bit we,
                       input int ack_at, input int hold,
                       input bit clr_on_err);
        int p, term, last_act, hh;
        bit pop, is_err, act;
        logic [NP-1:0] onehot;
        p = int'(adr[31:28]);
        pop = MAP[p];
        onehot = NP'(1) << p;
        if (!pop) begin
            is_err = 1; term = 1; last_act = 0;
        end else if (ack_at >= 1 && ack_at <= T) begin
            is_err = 0; term = ack_at; last_act = ack_at;
        end else begin
            is_err = 1; term = T + 1; last_act = T;
        end
        hh = is_err ? hold : 0;
        new_data();
        for (int c = 0; c <= term; c++) begin
            @(posedge clk_i); #1;
            if (c == 0) begin
                rst_i = 0; m_cyc = 1; m_stb = 1; m_we = we;
                m_adr = adr; m_sel = 4'($urandom); m_dat_i = $urandom;
            end
            p_ack = (!is_err && c == ack_at) ? onehot : '0;
            set_clr(clr_on_err && is_err && c == term);
            @(negedge clk_i);
            act = (c >= 1 && c <= last_act);
            chk("p_stb", 32'(p_stb), act ? 32'(onehot) : 0);
            chk("p_cyc", 32'(p_cyc), act ? 32'(onehot) : 0);
            chk("m_ack", 32'(m_ack), 32'(!is_err && c == term));
            chk("m_err", 32'(m_err), 32'(is_err && c == term));
            chk("bus_error", 32'(bus_error), 32'(is_err && c == term));
            chk("m_dat_o", m_dat_o, act ? pdat[p] : 0);
            if (act) begin
                chk("p_adr", p_adr, adr);
                chk("p_we", 32'(p_we), 32'(we));
            end
        end
`ifdef WB_DECODER_FAULT_LOG_EN
        if (is_err && (!fv_m || fault_clr)) begin
            fa_m = adr; fv_m = 1;
        end
`endif
        for (int h = 0; h <= hh; h++) begin
            @(posedge clk_i); #1;
            p_ack = '0;
            set_clr(0);
            if (h == hh) begin
                m_cyc = 0; m_stb = 0;
            end
            @(negedge clk_i);
            quiet("after");
            if (h == 0) chk_fault("fault");
        end
    endtask

    task automatic do_clr();
        @(posedge clk_i); #1;
        set_clr(1);
        @(posedge clk_i); #1;
        set_clr(0);
`ifdef WB_DECODER_FAULT_LOG_EN
        fv_m = 0;
`endif
        @(negedge clk_i);
        chk_fault("clr");
    endtask

    initial begin
        logic [31:0] a;
        int p;
        rst_i = 1; m_cyc = 0; m_stb = 0; m_we = 0;
        m_adr = 0; m_sel = 0; m_dat_i = 0;
        p_ack = '0; p_dat_i = '0;
`ifdef WB_DECODER_FAULT_LOG_EN
        fault_clr = 0; fa_m = 0; fv_m = 0;
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        quiet("reset");
        chk_fault("reset");

        // Write to port 3, acked on its second active cycle.
        txn(32'h3000_0004, 1, 2, 0, 0);
        // Unpopulated port 9.
        txn(32'h9000_0010, 0, 0, 0, 0);
        // Timeout with the master holding cyc in drain.
        txn(32'h5000_0000, 0, 0, 2, 0);
        // Ack on the last allowed cycle beats the timeout.
        txn(32'h1000_0008, 0, T, 0, 0);

        // Reset in the middle of an active transfer.
        @(posedge clk_i); #1;
        m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 32'h3000_0000;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("mid.p_stb", 32'(p_stb), 32'h0008);
        @(posedge clk_i); #1;
        rst_i = 1; p_ack = 16'h0008;
        @(posedge clk_i); #1;
        m_cyc = 0; m_stb = 0;
        @(negedge clk_i);
        quiet("mid_rst");
`ifdef WB_DECODER_FAULT_LOG_EN
        fv_m = 0; fa_m = 0;
`endif
        chk_fault("mid_rst");
        p_ack = '0;
        txn(32'h2000_0000, 1, 1, 0, 0);

        // Abort mid-transfer, then a full-length timeout.
        @(posedge clk_i); #1;
        m_cyc = 1; m_stb = 1; m_adr = 32'h2000_0040;
        repeat (4) @(posedge clk_i);
        #1 m_cyc = 0; m_stb = 0;
        @(negedge clk_i);
        chk("abort.p_cyc", 32'(p_cyc), 0);
        chk("abort.m_err", 32'(m_err), 0);
        txn(32'h2000_0044, 0, 0, 0, 0);

        // Log holds the first error until cleared.
        do_clr();
        txn(32'hA000_1000, 0, 0, 0, 0);
        txn(32'hC000_2000, 1, 0, 1, 0);
        do_clr();
        txn(32'hE000_3000, 0, 0, 0, 0);
        // Clear coinciding with an error captures the new address.
        txn(32'h4000_4000, 0, T + 3, 0, 1);

        for (int i = 0; i < 24; i++) begin
            p = int'($urandom_range(0, NP - 1));
            a = {4'(p), 28'($urandom)};
            txn(a, 1'($urandom), int'($urandom_range(0, T + 2)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
WB_DECODER -- requirements
Module: wb_decoder

Interface
REQ-001 Parameters SHALL be: NPORTS, default 16, number of downstream ports (power of two, 2..16).
REQ-002 Parameters SHALL be: BASE, default 28, lowest address bit of the port-select field.
REQ-003 Parameters SHALL be: PORT_MAP, default all ones, NPORTS-bit mask; bit n set means port n is populated.
REQ-004 Parameters SHALL be: TIMEOUT, default 1024, number of cycles without ack before a bus error is raised (2..65535).
REQ-005 Ports SHALL be:
  clk_i  in  1  system clock.
  rst_i  in  1  reset, synchronous, active-high.
  m_cyc, m_stb, m_we  in  1 each  upstream Wishbone controls.
  m_adr  in  32  upstream address.
  m_sel  in  4  upstream byte selects.
  m_dat_i  in  32  upstream write data.
  m_dat_o  out  32  upstream read data.
  m_ack, m_err  out  1 each  upstream termination.
  p_cyc, p_stb  out  NPORTS each  per-port controls.
  p_we, p_adr, p_sel, p_dat_o  out  1/32/4/32  broadcast to all ports.
  p_ack  in  NPORTS  per-port ack.
  p_dat_i  in  NPORTS*32  per-port read data; port n occupies bits [32n+31:32n].
  bus_error  out  1  one-cycle pulse on any error termination.

Function
REQ-006 Port select SHALL be m_adr[BASE+log2(NPORTS)-1:BASE], evaluated in IDLE only.
REQ-007 The FSM SHALL have four states: IDLE, ACTIVE, ERR and DRAIN.
REQ-008 In IDLE, m_cyc&m_stb with the selected port populated SHALL register the select, clear the timeout counter and go to ACTIVE; an unpopulated port SHALL go to ERR.
REQ-009 In ACTIVE, p_cyc/p_stb of the latched port SHALL follow m_cyc/m_stb; all other ports SHALL be 0.
REQ-010 In ACTIVE, m_ack SHALL equal p_ack of the latched port combinationally, and m_dat_o SHALL equal its p_dat_i.
REQ-011 Decode latency SHALL be exactly one cycle from stb to the port's p_stb.
REQ-012 In ACTIVE, an ack with m_cyc still high SHALL go to IDLE.
REQ-013 In ACTIVE, m_cyc low SHALL go to IDLE immediately (abort), and the counter SHALL be cleared.
REQ-014 In ACTIVE without ack, the counter SHALL increment each cycle; at count TIMEOUT-1 the FSM SHALL go to ERR and deassert p_stb.
REQ-015 An ack in the same cycle the count reaches TIMEOUT-1 SHALL win: no error is raised.
REQ-016 ERR SHALL assert m_err and bus_error for exactly one cycle, then go to DRAIN.
REQ-017 DRAIN SHALL hold all p_stb at 0 until m_cyc=0, then go to IDLE.
REQ-018 The counter SHALL be 16 bits and SHALL saturate, never wrap.
REQ-019 m_ack and m_err SHALL never be high in the same cycle.
REQ-020 m_dat_o SHALL be 0 outside ACTIVE.

Reset
REQ-021 rst_i SHALL force IDLE, counter 0, latched select 0, and all outputs 0 (m_ack, m_err, bus_error, p_cyc, p_stb, m_dat_o), including when asserted mid-transaction.
REQ-022 The first cycle after reset release SHALL accept a new strobe.

Configuration
REQ-023 The macro WB_DECODER_FAULT_LOG_EN, when defined, SHALL add outputs fault_adr (32 bits) and fault_valid, and input fault_clr; with the macro undefined these ports SHALL be absent and no log registers are built.
REQ-024 With the macro defined, the first error SHALL capture m_adr into fault_adr and set fault_valid.
REQ-025 With the macro defined, later errors SHALL NOT overwrite fault_adr while fault_valid=1.
REQ-026 With the macro defined, fault_clr SHALL clear fault_valid; if fault_clr coincides with an error, the new address SHALL be captured and fault_valid SHALL stay 1.
REQ-027 With the macro defined, reset SHALL clear fault_adr and fault_valid to 0.

Structure
REQ-028 The FSM state enum, the 16-bit counter width constant and the default TIMEOUT value SHALL live in package wb_decoder_pkg.
REQ-029 The timeout counter SHALL be a separate sub-module, wb_timeout, with inputs clr and run and output expired.

Verification
REQ-030 Write to 0x3000_0004 (port 3), port acks after 2 cycles -> p_stb[3] high one cycle after m_stb; m_ack high one cycle; no other p_stb.
REQ-031 Read from an address selecting an unpopulated port with PORT_MAP=16'h00FF (port 9) -> m_err one cycle after stb; bus_error pulse; fault_adr equals the address.
REQ-032 TIMEOUT=8, port never acks -> m_err exactly 8 cycles after ACTIVE entry; p_stb low in DRAIN until m_cyc drops.
REQ-033 TIMEOUT=8, port acks on the 8th ACTIVE cycle -> m_ack, no m_err, no bus_error.
REQ-034 rst_i asserted during ACTIVE -> next cycle all p_stb, m_ack and m_err are 0; a new transaction decodes normally afterwards.
REQ-035 Two successive errors, then fault_clr, then a third error -> fault_adr holds the first address until the clear, then the third address.
